sprite_compositor: RTL
======================

# sprite_compositor

Parametrised successor to the single-rectangle screen renderer: it composites up to N_OBJ coloured rectangles over a solid background colour, with fixed index priority, and drives the VGA colour outputs. Its inputs are the pixel coordinate, active flag and frame-start strobe from the existing `vga` timing instance. Game logic writes object positions, sizes and colours into a shadow table at any time. The shadow table is copied to the live table only at a frame boundary, so a frame never tears. The block also reports, once per frame, which objects overlapped object 0 (the ship).

## Interface
- `N_OBJ`, 4: number of objects, 2..16.
- `COORD_W`, 10: width of coordinate and size fields.
- `H_OFFSET`, 144: horizontal offset from object space to the VGA counter.
- `V_OFFSET`, 35: vertical offset from object space to the VGA counter.
- `BG_COLOR`, 24'h003232: background colour as {R,G,B}.

- `CLOCK_50`  in  1  system clock; every register is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pix_x`  in  COORD_W  VGA horizontal counter.
- `pix_y`  in  COORD_W  VGA vertical counter.
- `pix_ativo`  in  1  current pixel is in the visible area.
- `frame_start`  in  1  one-cycle pulse at the start of each frame, during blanking.
- `obj_we`  in  1  write strobe for the shadow table entry.
- `obj_idx`  in  clog2(N_OBJ)  index of the entry being written.
- `obj_x`  in  COORD_W  object X position.
- `obj_y`  in  COORD_W  object Y position.
- `obj_w`  in  COORD_W  object width field.
- `obj_h`  in  COORD_W  object height field.
- `obj_color`  in  24  object colour as {R,G,B}.
- `obj_en`  in  1  object is visible.
- `obj_commit`  in  1  request to copy shadow to live at the next frame_start.
- `commit_done`  out  1  one-cycle pulse when the copy happens.
- `commit_pending`  out  1  a commit is queued but not yet done.
- `coll_mask`  out  N_OBJ  bit k = object 0 overlapped object k in the previous frame; bit 0 is always 0.
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  registered colour outputs.
- `pix_valid`  out  1  `pix_ativo` delayed to align with the colour outputs.

## Operation
- Object tables:
  - Two tables exist, shadow and live. Each entry holds {x, y, w, h, color, en}.
  - When `obj_we`=1, the entry at `obj_idx` in the shadow table takes the input values in that cycle.
  - Writes with `obj_idx` ≥ N_OBJ are ignored.
  - Writes are always accepted; there is no backpressure.
- Commit:
  - `obj_commit` sets `commit_pending`.
  - On a cycle where `frame_start`=1 and (`commit_pending`=1 or `obj_commit`=1):
    - the live table takes all shadow entries;
    - `commit_pending` is cleared;
    - `commit_done` pulses for one cycle.
  - If `obj_we` and the copy fall in the same cycle, the copy uses the shadow contents from before that write. The write lands in shadow only and waits for the next commit.
  - Repeated `obj_commit` pulses before a frame_start merge into a single commit.
- Hit test for object k (uses the live table):
  - Condition: `en` and x+H_OFFSET ≤ `pix_x` ≤ x+H_OFFSET+w and y+V_OFFSET ≤ `pix_y` ≤ y+V_OFFSET+h.
  - Both bounds are inclusive, so the object spans w+1 pixels horizontally and h+1 lines vertically.
  - The sums are computed at COORD_W+2 bits, so they never wrap. A rectangle that extends past the counter range is clipped, not wrapped.
- Colour select:
  - If `pix_ativo`=0, the output is 0/0/0.
  - Otherwise the output is the colour of the lowest-index object that hits.
  - If no object hits, the output is BG_COLOR.
- Collision:
  - On each cycle with `pix_ativo`=1 and hit[0]=1, an internal accumulator ORs in hit[k] for every k ≥ 1.
  - On `frame_start`, `coll_mask` takes the accumulator value including the current cycle's hits, and the accumulator clears.
- Reset:
  - All outputs go to 0: RGB, `pix_valid`, `coll_mask`, `commit_done`, `commit_pending`.
  - Both tables are zeroed with `en`=0, and the collision accumulator is cleared.
  - Reset asserted mid-frame takes effect immediately. After release the block shows background only, until a commit occurs.

## Timing
- The pixel path is a fixed two-stage pipeline with latency 2 cycles:
  - Stage 1 registers the per-object hit vector and `pix_ativo`.
  - Stage 2 registers the RGB outputs and `pix_valid`.
  - Inputs at cycle t appear on RGB and `pix_valid` at t+2.
- A shadow write at cycle t is readable from shadow at t+1.
- A commit that happens at cycle t affects the hit tests from cycle t+1, so colours change from t+3.
- `commit_done` and the `coll_mask` update are registered, both visible at t+1 after the frame_start cycle.
- `commit_pending` rises in the cycle after `obj_commit`.
- No combinational path exists from any input to any output.

## Test plan
- Reset low, then high, with `pix_ativo`=1 at pix (200,100) → RGB=00/32/32 two cycles later; `coll_mask`=0; `commit_pending`=0.
- Write obj0 {x=10,y=5,w=3,h=2,red,en}, commit, pulse frame_start, then scan row `pix_y`=40 → red exactly for `pix_x` 154..157 and background at 153 and 158; row 43 is background.
- Obj0 and obj1 overlap, with obj1 green → the overlap region is red (index priority); `coll_mask`=4'b0010 after the next frame_start, and 0 after a further frame with no overlap.
- Write obj2 without `obj_commit`, then frame_start → no change on screen and no `commit_done`. Then `obj_commit` and `obj_we` in the same cycle as frame_start → copy excludes that write; `commit_done` pulses once.
- Edge cases: `obj_x`=1023 with `w`=10 → never draws, no wrap to column 0; `obj_idx`=N_OBJ write → ignored.
- Reset asserted mid-frame with objects live → RGB=0 asynchronously; after release the screen is background only.

Source files
------------

// File: rtl/sprite_compositor.sv
// sprite_compositor: composites up to N_OBJ coloured rectangles over a solid background colour
// and drives the VGA colour outputs through a two-stage pixel pipeline.
//
// Game logic may write the shadow table at any time. The shadow table is copied to the live
// table only on a frame_start, so a frame never tears. Object 0 is the ship: coll_mask reports,
// once per frame, which other objects it overlapped during the previous frame.
//
// Ports:
//   CLOCK_50, reset            clock (rising edge), asynchronous active-low reset
//   pix_x, pix_y, pix_ativo    pixel coordinate and visible-area flag from the VGA timing block
//   frame_start                one-cycle pulse per frame, during blanking
//   obj_we, obj_idx, obj_*     shadow table write port
//   obj_commit                 request a shadow-to-live copy at the next frame_start
//   commit_done                one-cycle pulse when the copy happens
//   commit_pending             a commit is queued but not yet done
//   coll_mask                  objects that overlapped object 0 in the previous frame
//   VGA_R/G/B, pix_valid       registered colour outputs and aligned active flag
module sprite_compositor #(
    parameter int unsigned N_OBJ    = 4,
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned H_OFFSET = 144,
    parameter int unsigned V_OFFSET = 35,
    parameter logic [23:0] BG_COLOR = 24'h003232
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [COORD_W-1:0]         pix_x,
    input  logic [COORD_W-1:0]         pix_y,
    input  logic                       pix_ativo,
    input  logic                       frame_start,
    input  logic                       obj_we,
    input  logic [$clog2(N_OBJ)-1:0]   obj_idx,
    input  logic [COORD_W-1:0]         obj_x,
    input  logic [COORD_W-1:0]         obj_y,
    input  logic [COORD_W-1:0]         obj_w,
    input  logic [COORD_W-1:0]         obj_h,
    input  logic [23:0]                obj_color,
    input  logic                       obj_en,
    input  logic                       obj_commit,
    output logic                       commit_done,
    output logic                       commit_pending,
    output logic [N_OBJ-1:0]           coll_mask,
    output logic [7:0]                 VGA_R,
    output logic [7:0]                 VGA_G,
    output logic [7:0]                 VGA_B,
    output logic                       pix_valid
);

    // Two guard bits so position + offset + size never wraps; oversized rectangles clip.
    localparam int unsigned SW    = COORD_W + 2;
    localparam int unsigned IDX_W = $clog2(N_OBJ);

    logic [COORD_W-1:0] sh_x_q [N_OBJ];
    logic [COORD_W-1:0] sh_y_q [N_OBJ];
    logic [COORD_W-1:0] sh_w_q [N_OBJ];
    logic [COORD_W-1:0] sh_h_q [N_OBJ];
    logic [23:0]        sh_c_q [N_OBJ];
    logic [N_OBJ-1:0]   sh_en_q;

    logic [COORD_W-1:0] lv_x_q [N_OBJ];
    logic [COORD_W-1:0] lv_y_q [N_OBJ];
    logic [COORD_W-1:0] lv_w_q [N_OBJ];
    logic [COORD_W-1:0] lv_h_q [N_OBJ];
    logic [23:0]        lv_c_q [N_OBJ];
    logic [N_OBJ-1:0]   lv_en_q;

    logic               commit_go;
    logic               pend_q, done_q;
    logic [N_OBJ-1:0]   hit, hit_q;
    logic [N_OBJ-1:0]   acc_d, acc_q, coll_q;
    logic               ativo_q, valid_q;
    logic [23:0]        rgb_d, rgb_q;

    assign commit_go = frame_start & (pend_q | obj_commit);

    // Tables. The copy reads shadow through non-blocking semantics, so a write in the same
    // cycle as the copy lands in shadow only. Indices with no matching entry are dropped.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(N_OBJ); k++) begin
                sh_x_q[k] <= '0;
                sh_y_q[k] <= '0;
                sh_w_q[k] <= '0;
                sh_h_q[k] <= '0;
                sh_c_q[k] <= '0;
                lv_x_q[k] <= '0;
                lv_y_q[k] <= '0;
                lv_w_q[k] <= '0;
                lv_h_q[k] <= '0;
                lv_c_q[k] <= '0;
            end
            sh_en_q <= '0;
            lv_en_q <= '0;
        end else begin
            for (int k = 0; k < int'(N_OBJ); k++) begin
                if (commit_go) begin
                    lv_x_q[k]  <= sh_x_q[k];
                    lv_y_q[k]  <= sh_y_q[k];
                    lv_w_q[k]  <= sh_w_q[k];
                    lv_h_q[k]  <= sh_h_q[k];
                    lv_c_q[k]  <= sh_c_q[k];
                    lv_en_q[k] <= sh_en_q[k];
                end
                if (obj_we && obj_idx == IDX_W'(k)) begin
                    sh_x_q[k]  <= obj_x;
                    sh_y_q[k]  <= obj_y;
                    sh_w_q[k]  <= obj_w;
                    sh_h_q[k]  <= obj_h;
                    sh_c_q[k]  <= obj_color;
                    sh_en_q[k] <= obj_en;
                end
            end
        end
    end

    // Per-object hit test against the live table; both bounds inclusive.
    for (genvar k = 0; k < int'(N_OBJ); k++) begin : g_hit
        logic [SW-1:0] lo_x, hi_x, lo_y, hi_y;
        assign lo_x   = SW'(lv_x_q[k]) + SW'(H_OFFSET);
        assign hi_x   = lo_x + SW'(lv_w_q[k]);
        assign lo_y   = SW'(lv_y_q[k]) + SW'(V_OFFSET);
        assign hi_y   = lo_y + SW'(lv_h_q[k]);
        assign hit[k] = lv_en_q[k]
                        && (SW'(pix_x) >= lo_x) && (SW'(pix_x) <= hi_x)
                        && (SW'(pix_y) >= lo_y) && (SW'(pix_y) <= hi_y);
    end

    // Collision accumulator: only pixels where the ship is drawn count; bit 0 stays clear.
    always_comb begin
        acc_d = acc_q;
        if (pix_ativo && hit[0]) begin
            acc_d = acc_q | (hit & ~N_OBJ'(1));
        end
    end

    // Stage-2 colour: lowest index wins, so scan from the top down and let lower ones override.
    always_comb begin
        rgb_d = BG_COLOR;
        for (int k = int'(N_OBJ) - 1; k >= 0; k--) begin
            if (hit_q[k]) begin
                rgb_d = lv_c_q[k];
            end
        end
        if (!ativo_q) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= '0;
            coll_q  <= '0;
            hit_q   <= '0;
            ativo_q <= 1'b0;
            rgb_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            done_q <= commit_go;
            if (commit_go) begin
                pend_q <= 1'b0;
            end else if (obj_commit) begin
                pend_q <= 1'b1;
            end
            if (frame_start) begin
                coll_q <= acc_d;
                acc_q  <= '0;
            end else begin
                acc_q  <= acc_d;
            end
            hit_q   <= hit;
            ativo_q <= pix_ativo;
            rgb_q   <= rgb_d;
            valid_q <= ativo_q;
        end
    end

    assign commit_done    = done_q;
    assign commit_pending = pend_q;
    assign coll_mask      = coll_q;
    assign VGA_R          = rgb_q[23:16];
    assign VGA_G          = rgb_q[15:8];
    assign VGA_B          = rgb_q[7:0];
    assign pix_valid      = valid_q;

endmodule
